// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: size encodings, the queued entry layout and
// the byte-enable helper used by both the store path and the load-overlap path.
package store_buffer_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_BYTES = MAX_W / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Sized for the widest bus; narrower instances leave the upper bits zero.
  typedef struct packed {
    logic [31:0]           addr;
    logic [MAX_W-1:0]      wdata;
    logic [MAX_BYTES-1:0]  byteen;
    logic [31:0]           pc;
  } entry_t;

  function automatic logic [MAX_BYTES-1:0] byteen_of(input size_e size,
                                                     input logic [2:0] offset);
    logic [MAX_BYTES-1:0] ones;
    case (size)
      SZ_B:    ones = 8'h01;
      SZ_H:    ones = 8'h03;
      SZ_W:    ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ones << offset;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Maps (address offset, size, right-justified data) onto bus lanes: lane-aligned
// write data with idle lanes zeroed, byte enables, and a misalignment flag.
module store_lane_align
  import store_buffer_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF    = $clog2(BYTES)
) (
  input  logic [OFF-1:0]    offset_i,
  input  logic [1:0]        size_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [BYTES-1:0]  byteen_o,
  output logic              misaligned_o
);

  size_e                size;
  logic [MAX_BYTES-1:0] be_full;
  logic [MAX_BYTES-1:0] lane_keep;
  logic [DATA_W-1:0]    keep;
  logic [OFF-1:0]       align_mask;
  logic                 illegal_size;
  logic                 unused_hi;

  assign size      = size_e'(size_i);
  assign be_full   = byteen_of(size, 3'(offset_i));
  assign lane_keep = byteen_of(size, 3'd0);
  assign byteen_o  = be_full[BYTES-1:0];
  assign unused_hi = ^{be_full, lane_keep};

  // NOTE: every output of a combinational block is assigned on every path
  // (here by a loop covering all lanes), so no latch can be inferred.
  always_comb begin
    for (int b = 0; b < BYTES; b++) begin
      keep[8*b +: 8] = {8{lane_keep[b]}};
    end
  end

  // Masking before the shift guarantees lanes outside the access read as zero.
  assign wdata_o = (data_i & keep) << {offset_i, 3'b000};

  assign align_mask   = OFF'((4'd1 << size_i) - 4'd1);
  assign illegal_size = (DATA_W == 32) && (size == SZ_D);
  assign misaligned_o = illegal_size || (|(offset_i & align_mask));

endmodule

// File: rtl/store_buffer.sv
// In-order store queue between the M stage and the data-memory bus, with
// misaligned-store detection and a load-overlap hazard flag.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF    = $clog2(BYTES),
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  input  logic [31:0]       st_pc,
  output logic              st_exc,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [1:0]        ld_size,
  output logic              ld_hit,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data_addr,
  output logic [DATA_W-1:0] m_data_wdata,
  output logic [BYTES-1:0]  m_data_byteen,
  output logic [31:0]       m_inst_addr,
  output logic [CW-1:0]     count,
  output logic              empty
);

  entry_t            mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              full, enq, deq, hit;
  logic [DATA_W-1:0] st_wdata, ld_wdata;
  logic [BYTES-1:0]  st_be, ld_be;
  logic              st_mis, ld_mis;
  entry_t            new_e, head_e;
  logic              unused_bits;

  store_lane_align #(.DATA_W(DATA_W)) u_st_align (
    .offset_i     (st_addr[OFF-1:0]),
    .size_i       (st_size),
    .data_i       (st_data),
    .wdata_o      (st_wdata),
    .byteen_o     (st_be),
    .misaligned_o (st_mis)
  );

  // Only the byte enables matter for a load; data and alignment are ignored.
  store_lane_align #(.DATA_W(DATA_W)) u_ld_align (
    .offset_i     (ld_addr[OFF-1:0]),
    .size_i       (ld_size),
    .data_i       ('0),
    .wdata_o      (ld_wdata),
    .byteen_o     (ld_be),
    .misaligned_o (ld_mis)
  );

  assign full     = (count_q == CW'(DEPTH));
  assign st_ready = !full;
  assign st_exc   = st_valid && st_mis;
  assign enq      = st_valid && st_ready && !st_mis;
  assign m_valid  = (count_q != '0);
  assign deq      = m_valid && m_ready;

  always_comb begin
    new_e                     = '0;
    new_e.addr                = {st_addr[31:OFF], {OFF{1'b0}}};
    new_e.wdata[DATA_W-1:0]   = st_wdata;
    new_e.byteen[BYTES-1:0]   = st_be;
    new_e.pc                  = st_pc;
  end

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry array is deliberately not reset; valid_q and count_q gate
  // every use of it, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= new_e;
    end
  end

  assign head_e        = mem_q[rd_ptr_q];
  assign m_data_addr   = m_valid ? head_e.addr                : '0;
  assign m_data_wdata  = m_valid ? head_e.wdata[DATA_W-1:0]   : '0;
  assign m_data_byteen = m_valid ? head_e.byteen[BYTES-1:0]   : '0;
  assign m_inst_addr   = m_valid ? head_e.pc                  : '0;
  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign unused_bits   = ^{head_e, ld_wdata, ld_mis};

  // A draining head still blocks the load; an entry being written this cycle does not.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].addr[31:OFF] == ld_addr[31:OFF]) &&
          (|(mem_q[i].byteen[BYTES-1:0] & ld_be))) begin
        hit = 1'b1;
      end
    end
  end

  assign ld_hit = ld_valid && hit;

endmodule

// File: tb/tb_store_buffer.sv
// Drives one directed stimulus stream into a 32-bit and a 64-bit store buffer and
// checks both against a queue model every cycle, plus hand-computed spot values.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic [31:0] st_pc;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        m_ready;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] wd;
    logic [7:0]  be;
    logic [31:0] pc;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference rules: nb = bytes on the bus.
  function automatic bit mis_model(input int nb, input logic [31:0] a, input logic [1:0] sz);
    return ((a % (32'd1 << sz)) != 0) || (sz == 2'd3 && nb == 4);
  endfunction

  function automatic logic [7:0] be_model(input int nb, input logic [31:0] a, input logic [1:0] sz);
    int n;
    int off;
    logic [7:0] r;
    n   = 1 << sz;
    off = int'(a % 32'(nb));
    r   = '0;
    for (int k = 0; k < n; k++) if (off + k < nb) r[off+k] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] wd_model(input int nb, input logic [31:0] a,
                                          input logic [1:0] sz, input logic [63:0] d);
    int n;
    int off;
    logic [63:0] r;
    n   = 1 << sz;
    off = int'(a % 32'(nb));
    r   = '0;
    for (int k = 0; k < n; k++) if (off + k < nb) r[8*(off+k) +: 8] = d[8*k +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W  = 32 * (g + 1);
    localparam int NB = W / 8;

    logic          st_ready, st_exc, ld_hit, m_valid, empty;
    logic [31:0]   m_addr, m_pc;
    logic [W-1:0]  m_wdata;
    logic [NB-1:0] m_be;
    logic [2:0]    count;
    exp_t          exp_q[$];

    store_buffer #(.DATA_W(W), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .st_valid      (st_valid),
      .st_ready      (st_ready),
      .st_addr       (st_addr),
      .st_data       (st_data[W-1:0]),
      .st_size       (st_size),
      .st_pc         (st_pc),
      .st_exc        (st_exc),
      .ld_valid      (ld_valid),
      .ld_addr       (ld_addr),
      .ld_size       (ld_size),
      .ld_hit        (ld_hit),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data_addr   (m_addr),
      .m_data_wdata  (m_wdata),
      .m_data_byteen (m_be),
      .m_inst_addr   (m_pc),
      .count         (count),
      .empty         (empty)
    );

    task automatic cmp(input string what, input logic [63:0] act, input logic [63:0] exp);
      check($sformatf("w%0d %s", W, what), act, exp);
    endtask

    function automatic bit hit_model();
      logic [7:0] lbe;
      bit h;
      lbe = be_model(NB, ld_addr, ld_size);
      h   = 1'b0;
      foreach (exp_q[i])
        if (exp_q[i].addr == (ld_addr & ~32'(NB - 1)) && (exp_q[i].be & lbe) != 8'h00) h = 1'b1;
      return ld_valid && h;
    endfunction

    always @(posedge clk) begin
      if (reset) begin
        exp_q.delete();
      end else begin
        bit acc;
        acc = st_valid && !mis_model(NB, st_addr, st_size) && (exp_q.size() < DEPTH);
        if (m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back('{addr: st_addr & ~32'(NB - 1),
                                   wd:   wd_model(NB, st_addr, st_size, st_data),
                                   be:   be_model(NB, st_addr, st_size),
                                   pc:   st_pc});
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        int n;
        n = exp_q.size();
        cmp("st_ready", 64'(st_ready), 64'(n < DEPTH));
        cmp("count",    64'(count),    64'(n));
        cmp("empty",    64'(empty),    64'(n == 0));
        cmp("m_valid",  64'(m_valid),  64'(n != 0));
        cmp("st_exc",   64'(st_exc),   64'(st_valid && mis_model(NB, st_addr, st_size)));
        cmp("ld_hit",   64'(ld_hit),   64'(hit_model()));
        if (n != 0) begin
          cmp("m_addr",  64'(m_addr),  64'(exp_q[0].addr));
          cmp("m_wdata", 64'(m_wdata), exp_q[0].wd);
          cmp("m_be",    64'(m_be),    64'(exp_q[0].be));
          cmp("m_pc",    64'(m_pc),    64'(exp_q[0].pc));
        end else begin
          cmp("idle m_be", 64'(m_be), 64'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; st_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_size = '0;
  endtask

  task automatic put(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz; st_pc = 32'h8000_0000 | a;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz);
    ld_valid = 1'b1; ld_addr = a; ld_size = sz;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); m_ready = 1'b0; reset = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst count",   64'(g_dut[0].count),   64'd0);
    check("rst empty",   64'(g_dut[0].empty),   64'd1);
    check("rst m_valid", 64'(g_dut[0].m_valid), 64'd0);
    check("rst addr",    64'(g_dut[0].m_addr),  64'd0);
    check("rst wdata",   64'(g_dut[0].m_wdata), 64'd0);
    check("rst pc",      64'(g_dut[0].m_pc),    64'd0);

    // sb at 0x1003 lands in lane 3
    tick(); reset = 1'b0; put(32'h1003, 64'hAB, 2'd0);
    @(negedge clk);
    check("sb st_exc", 64'(g_dut[0].st_exc), 64'd0);
    tick(); idle(); m_ready = 1'b1;
    @(negedge clk);
    check("sb m_valid", 64'(g_dut[0].m_valid), 64'd1);
    check("sb addr",    64'(g_dut[0].m_addr),  64'h1000);
    check("sb be",      64'(g_dut[0].m_be),    64'h8);
    check("sb wdata",   64'(g_dut[0].m_wdata), 64'hAB00_0000);
    check("sb w64 wdata", 64'(g_dut[1].m_wdata), 64'h0000_0000_AB00_0000);

    // sh aligned, then sh misaligned
    tick(); m_ready = 1'b0; put(32'h2002, 64'h1234, 2'd1);
    tick(); idle(); m_ready = 1'b1;
    @(negedge clk);
    check("sh be",    64'(g_dut[0].m_be),    64'hC);
    check("sh wdata", 64'(g_dut[0].m_wdata), 64'h1234_0000);
    tick(); m_ready = 1'b0; put(32'h2001, 64'h1234, 2'd1);
    @(negedge clk);
    check("sh mis st_exc",     64'(g_dut[0].st_exc), 64'd1);
    check("sh mis w64 st_exc", 64'(g_dut[1].st_exc), 64'd1);
    tick(); idle();
    @(negedge clk);
    check("sh mis count",   64'(g_dut[0].count),   64'd0);
    check("sh mis m_valid", 64'(g_dut[0].m_valid), 64'd0);

    // five back-to-back sw into a 4-deep buffer with memory stalled
    tick();
    for (int i = 0; i < 4; i++) begin
      put(32'(32'h5000 + 4 * i), 64'(64'h1111_0000 + i), 2'd2);
      tick();
    end
    put(32'h5010, 64'h1111_0004, 2'd2);
    @(negedge clk);
    check("full st_ready", 64'(g_dut[0].st_ready), 64'd0);
    check("full count",    64'(g_dut[0].count),    64'd4);
    tick(); m_ready = 1'b1;
    @(negedge clk);
    check("full+drain st_ready", 64'(g_dut[0].st_ready), 64'd0);
    tick(); m_ready = 1'b0;
    @(negedge clk);
    check("after drain st_ready", 64'(g_dut[0].st_ready), 64'd1);
    tick(); idle();
    @(negedge clk);
    check("refill count", 64'(g_dut[0].count), 64'd4);
    tick(); m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("order head %0d", i), 64'(g_dut[0].m_addr), 64'(32'h5004 + 4 * i));
      tick();
    end
    m_ready = 1'b0;
    @(negedge clk);
    check("drained empty", 64'(g_dut[0].empty), 64'd1);

    // load-overlap hazard
    tick(); put(32'h3001, 64'h5A, 2'd0);
    tick(); idle(); load(32'h3001, 2'd0);
    @(negedge clk);
    check("lb same byte hit", 64'(g_dut[0].ld_hit), 64'd1);
    tick(); load(32'h3002, 2'd0);
    @(negedge clk);
    check("lb next byte hit", 64'(g_dut[0].ld_hit), 64'd0);
    tick(); load(32'h3000, 2'd2);
    @(negedge clk);
    check("lw word hit", 64'(g_dut[0].ld_hit), 64'd1);
    tick(); load(32'h3101, 2'd0);
    tick(); put(32'h3005, 64'h66, 2'd0); load(32'h3005, 2'd0);
    @(negedge clk);
    check("lb vs enqueuing store", 64'(g_dut[0].ld_hit), 64'd0);
    tick(); idle(); load(32'h3001, 2'd0); m_ready = 1'b1;
    @(negedge clk);
    check("lb vs dequeuing head", 64'(g_dut[0].ld_hit), 64'd1);
    tick(); idle();
    tick(); tick(); m_ready = 1'b0;

    // 64-bit lanes: sd legal only on the wide bus
    put(32'h4008, 64'h1122_3344_5566_7788, 2'd3);
    @(negedge clk);
    check("sd w32 st_exc", 64'(g_dut[0].st_exc), 64'd1);
    check("sd w64 st_exc", 64'(g_dut[1].st_exc), 64'd0);
    tick(); idle(); m_ready = 1'b1;
    @(negedge clk);
    check("sd w64 be",    64'(g_dut[1].m_be),    64'hFF);
    check("sd w64 addr",  64'(g_dut[1].m_addr),  64'h4008);
    check("sd w64 wdata", 64'(g_dut[1].m_wdata), 64'h1122_3344_5566_7788);
    check("sd w32 count", 64'(g_dut[0].count),   64'd0);
    tick(); m_ready = 1'b0; put(32'h4004, 64'hCAFE_BABE, 2'd2);
    tick(); put(32'h4001, 64'h5A, 2'd0);
    @(negedge clk);
    check("sw w64 be",    64'(g_dut[1].m_be),    64'hF0);
    check("sw w64 wdata", 64'(g_dut[1].m_wdata), 64'hCAFE_BABE_0000_0000);
    check("sw w32 be",    64'(g_dut[0].m_be),    64'hF);
    tick(); put(32'h4002, 64'h7788, 2'd1);
    tick(); idle(); m_ready = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("pre-reset w64 count", 64'(g_dut[1].count), 64'd3);
    tick(); reset = 1'b0;
    @(negedge clk);
    check("reset w64 count",   64'(g_dut[1].count),   64'd0);
    check("reset w64 m_valid", 64'(g_dut[1].m_valid), 64'd0);
    check("reset w64 be",      64'(g_dut[1].m_be),    64'd0);

    // mixed traffic: simultaneous enqueue/dequeue and pointer wrap
    for (int i = 0; i < 14; i++) begin
      tick();
      m_ready = (i % 3) != 0;
      put(32'(32'h7000 + 8 * i + ((i % 4 == 0) ? 1 : 0)), 64'h0123_4567_89AB_CDEF ^ 64'(i * 32'h0101_0101),
          2'(i % 4));
      load(32'(32'h7000 + 8 * i - 8), 2'(i % 3));
    end
    tick(); idle(); m_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    check("final empty", 64'(g_dut[0].empty), 64'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
